// File: rtl/branch_resolve_queue_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue_if
//   Groups the D-stage push signals, the M-stage resolve signals and every
//   status/result output of branch_resolve_queue.
//
//   master : drives the D/M stage inputs (the pipeline, or a testbench)
//   slave  : the queue itself
//
//   D stage  : branchD, stallD, flushD, pcD, pred_takeD, ghrD
//   M stage  : branchM, actual_takeM, actual_targetM
//   Status   : full, empty, count
//   Redirect : redirect_valid, redirect_pc, restore_ghr
//   GPHT upd : upd_valid, upd_index, upd_take
//   Stats    : branch_cnt, mispred_cnt, overflow_err, underflow_err
// -----------------------------------------------------------------------------
interface branch_resolve_queue_if #(
   parameter int GHR_WIDTH = 6,
   parameter int DEPTH     = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                   branchD;
   logic                   stallD;
   logic                   flushD;
   logic [31:0]            pcD;
   logic                   pred_takeD;
   logic [GHR_WIDTH-1:0]   ghrD;
   logic                   branchM;
   logic                   actual_takeM;
   logic [31:0]            actual_targetM;

   logic                   full;
   logic                   empty;
   logic [CNT_W-1:0]       count;
   logic                   redirect_valid;
   logic [31:0]            redirect_pc;
   logic [GHR_WIDTH-1:0]   restore_ghr;
   logic                   upd_valid;
   logic [GHR_WIDTH+2:0]   upd_index;
   logic                   upd_take;
   logic [31:0]            branch_cnt;
   logic [31:0]            mispred_cnt;
   logic                   overflow_err;
   logic                   underflow_err;

   modport master (
      output branchD, stallD, flushD, pcD, pred_takeD, ghrD,
      output branchM, actual_takeM, actual_targetM,
      input  full, empty, count,
      input  redirect_valid, redirect_pc, restore_ghr,
      input  upd_valid, upd_index, upd_take,
      input  branch_cnt, mispred_cnt, overflow_err, underflow_err
   );

   modport slave (
      input  branchD, stallD, flushD, pcD, pred_takeD, ghrD,
      input  branchM, actual_takeM, actual_targetM,
      output full, empty, count,
      output redirect_valid, redirect_pc, restore_ghr,
      output upd_valid, upd_index, upd_take,
      output branch_cnt, mispred_cnt, overflow_err, underflow_err
   );
endinterface

// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//   In-order queue of predicted branches. An entry {pc, pred_take, ghr} is
//   pushed when a branch leaves D and popped when it resolves in M. Each pop
//   produces a registered GPHT update packet one cycle later; a mispredicting
//   pop additionally produces a redirect PC and a corrected GHR and squashes
//   every younger (wrong-path) entry.
//
// Ports
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : branch_resolve_queue_if.slave (D push, M resolve, all outputs)
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
   parameter int GHR_WIDTH    = 6,
   parameter int DEPTH        = 4,
   parameter int FALLTHRU_OFS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   branch_resolve_queue_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = GHR_WIDTH + 3;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Entry storage: no reset, contents are don't-care until written.
   logic [31:0]          pc_mem  [DEPTH];
   logic                 pt_mem  [DEPTH];
   logic [GHR_WIDTH-1:0] ghr_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic                 redir_vld_q, redir_vld_d;
   logic [31:0]          redir_pc_q,  redir_pc_d;
   logic [GHR_WIDTH-1:0] restore_q,   restore_d;
   logic                 upd_vld_q,   upd_vld_d;
   logic [IDX_W-1:0]     upd_idx_q,   upd_idx_d;
   logic                 upd_take_q,  upd_take_d;
   logic [31:0]          bcnt_q,      bcnt_d;
   logic [31:0]          mcnt_q,      mcnt_d;
   logic                 ovf_q,       ovf_d;
   logic                 unf_q,       unf_d;

   logic                 full_w, empty_w;
   logic                 push_req, pop, mispred, push_ok;
   logic [31:0]          head_pc;
   logic                 head_pt;
   logic [GHR_WIDTH-1:0] head_ghr;

   assign full_w  = (count_q == CNT_W'(DEPTH));
   assign empty_w = (count_q == '0);

   assign head_pc  = pc_mem[rd_ptr_q];
   assign head_pt  = pt_mem[rd_ptr_q];
   assign head_ghr = ghr_mem[rd_ptr_q];

   assign push_req = bus.branchD & ~bus.stallD & ~bus.flushD;
   assign pop      = bus.branchM & ~empty_w;
   assign mispred  = pop & (head_pt ^ bus.actual_takeM);
   // A pop frees a slot in the same cycle, so push-while-full is legal with a
   // pop. Any push alongside a mispredict is wrong-path and is dropped.
   assign push_ok  = push_req & (~full_w | pop) & ~mispred;

   // Storage write
   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_mem[wr_ptr_q]  <= bus.pcD;
         pt_mem[wr_ptr_q]  <= bus.pred_takeD;
         ghr_mem[wr_ptr_q] <= bus.ghrD;
      end
   end

   // Pointer / occupancy next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (mispred) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Result packet next state: pulses default low, data holds
   always_comb begin
      upd_vld_d   = pop;
      upd_idx_d   = upd_idx_q;
      upd_take_d  = upd_take_q;
      redir_vld_d = mispred;
      redir_pc_d  = redir_pc_q;
      restore_d   = restore_q;
      bcnt_d      = bcnt_q;
      mcnt_d      = mcnt_q;
      ovf_d       = ovf_q | (push_req & full_w & ~pop);
      unf_d       = unf_q | (bus.branchM & empty_w);
      if (pop) begin
         upd_idx_d  = {head_pc[4:2], head_ghr};
         upd_take_d = bus.actual_takeM;
         bcnt_d     = sat_inc(bcnt_q);
      end
      if (mispred) begin
         redir_pc_d = bus.actual_takeM ? bus.actual_targetM
                                       : head_pc + 32'(FALLTHRU_OFS);
         restore_d  = {head_ghr[GHR_WIDTH-2:0], bus.actual_takeM};
         mcnt_d     = sat_inc(mcnt_q);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         redir_vld_q <= 1'b0;
         redir_pc_q  <= '0;
         restore_q   <= '0;
         upd_vld_q   <= 1'b0;
         upd_idx_q   <= '0;
         upd_take_q  <= 1'b0;
         bcnt_q      <= '0;
         mcnt_q      <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         redir_vld_q <= redir_vld_d;
         redir_pc_q  <= redir_pc_d;
         restore_q   <= restore_d;
         upd_vld_q   <= upd_vld_d;
         upd_idx_q   <= upd_idx_d;
         upd_take_q  <= upd_take_d;
         bcnt_q      <= bcnt_d;
         mcnt_q      <= mcnt_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   assign bus.full           = full_w;
   assign bus.empty          = empty_w;
   assign bus.count          = count_q;
   assign bus.redirect_valid = redir_vld_q;
   assign bus.redirect_pc    = redir_pc_q;
   assign bus.restore_ghr    = restore_q;
   assign bus.upd_valid      = upd_vld_q;
   assign bus.upd_index      = upd_idx_q;
   assign bus.upd_take       = upd_take_q;
   assign bus.branch_cnt     = bcnt_q;
   assign bus.mispred_cnt    = mcnt_q;
   assign bus.overflow_err   = ovf_q;
   assign bus.underflow_err  = unf_q;
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
Resolution-side companion to the global branch predictor. It records every predicted branch when it leaves the D stage: PC, predicted direction, and the GHR snapshot used for the prediction. It retires entries in order when the branch resolves in the M stage, compares the prediction against the actual outcome, and then emits a registered redirect/flush request, a GHR restore value, and a GPHT update packet indexed exactly as the prediction was indexed. It also maintains branch and mispredict counters.

Parameters:
GHR_WIDTH, 6, global history width; must match the predictor.
DEPTH, 4, in-flight branch entries; power of two, ≥2.
FALLTHRU_OFS, 4, byte offset added to a branch PC to form the not-taken redirect target.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-low reset.
branchD  in  1  D-stage instruction is a branch.
stallD  in  1  D stage stalled.
flushD  in  1  D stage flushed.
pcD  in  32  PC of the D-stage branch.
pred_takeD  in  1  predicted direction for the D-stage branch.
ghrD  in  GHR_WIDTH  GHR value used to index the prediction.
branchM  in  1  M-stage instruction is a resolving branch.
actual_takeM  in  1  resolved direction.
actual_targetM  in  32  resolved taken target.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
count  out  clog2(DEPTH)+1  occupied entries.
redirect_valid  out  1  one-cycle registered mispredict pulse.
redirect_pc  out  32  correct fetch PC; valid with redirect_valid.
restore_ghr  out  GHR_WIDTH  corrected GHR; valid with redirect_valid.
upd_valid  out  1  one-cycle registered GPHT update pulse.
upd_index  out  GHR_WIDTH+3  {entry.pc[4:2], entry.ghr}.
upd_take  out  1  actual direction for the counter update.
branch_cnt  out  32  resolved branches.
mispred_cnt  out  32  mispredicted branches.
overflow_err  out  1  sticky; push attempted while full with no same-cycle pop.
underflow_err  out  1  sticky; branchM while empty.

Behaviour:
- Reset (rst=0, asynchronous): read/write pointers = 0, count = 0, empty = 1, full = 0. All pulse outputs, redirect_pc, restore_ghr, upd_index, upd_take, both counters and both error flags = 0. Storage contents are don't-care.
- Push condition: branchD & ~stallD & ~flushD. The entry {pcD, pred_takeD, ghrD} is written at the write pointer and the pointer increments modulo DEPTH.
- Pop condition: branchM & ~empty. The head entry is read combinationally from the read pointer; the pointer increments.
- Mispredict is defined as head.pred_take XOR actual_takeM, evaluated only on a pop.
- Outputs are registered, with one-cycle latency. In the cycle after a pop edge:
  - upd_valid = 1, upd_index = {head.pc[4:2], head.ghr}, upd_take = actual_takeM.
  - branch_cnt increments.
  - On a mispredict, additionally:
    - redirect_valid = 1.
    - redirect_pc = actual_takeM ? actual_targetM : head.pc + FALLTHRU_OFS (32-bit wrap).
    - restore_ghr = {head.ghr[GHR_WIDTH-2:0], actual_takeM}.
    - mispred_cnt increments.
  - Pulses last exactly one cycle. Data outputs hold their last value otherwise.
- Mispredict recovery: on the pop edge of a mispredicting branch, all younger entries are wrong-path. Both pointers reset to 0 and count = 0. A push in the same cycle is discarded and does not set overflow_err.
- Simultaneous push and pop with no mispredict: both take effect and count is unchanged. This is legal while full.
- Push while full with no pop: the push is dropped, overflow_err sets, and state is otherwise unchanged.
- branchM while empty: no pop, no pulses, underflow_err sets.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Pointer wrap: pointers are clog2(DEPTH) bits. Full and empty are derived from count, not from pointer equality.
- Asynchronous reset mid-operation clears pending pulses immediately; no redirect is emitted after reset release.

Test Plan:
- Reset then idle: rst low for 2 cycles, then high → count=0, empty=1, full=0, all pulses 0 for 10 cycles.
- Correct prediction: push pcD=0x0040_0010, pred_takeD=1, ghrD=6'b101010. Two cycles later branchM, actual_takeM=1 → next cycle upd_valid=1, upd_index=9'b100_101010, upd_take=1, redirect_valid=0, branch_cnt=1, mispred_cnt=0.
- Not-taken mispredict: push pcD=0x0040_0020, pred_takeD=1, ghrD=6'b000111. Resolve actual_takeM=0 → redirect_valid=1, redirect_pc=0x0040_0024, restore_ghr=6'b001110, mispred_cnt=1.
- Mispredict flush: push 3 branches (first predicted 0). Resolve the first with actual_takeM=1, actual_targetM=0x0040_0100, and push a fourth in the same cycle → redirect_pc=0x0040_0100, count=0 next cycle, overflow_err=0. A subsequent branchM sets underflow_err.
- Full boundary (DEPTH=4): push 4 → full=1. A 5th push alone → overflow_err=1, count=4. Push and pop (correct) in the same cycle → count stays 4, write pointer wraps to 1.
- Stall/flush gating: branchD=1 with stallD=1 for 3 cycles, then flushD=1 → no entries written, count=0.
